// File: rtl/src_sync_tx_if.sv
// -----------------------------------------------------------------------------
// src_sync_tx_if
//   Bundles the parallel-word handshake and the forwarded serial link of
//   src_sync_tx.
//
//   Handshake semantics: a word transfers on a rising clk edge where both
//   data_valid and data_ready are high. data_in is sampled only on that edge.
//   The source may raise data_valid at any time and keeps data_in stable
//   until the transfer. Deasserting data_valid before the transfer withdraws
//   the offer.
//
//   Signals:
//     data_in    [WIDTH-1:0]  word to send (source -> tx)
//     data_valid              word available (source -> tx)
//     data_ready              tx can accept a word (tx -> source)
//     clk_out                 forwarded clock (tx -> link)
//     data_out                serial data, MSB first (tx -> link)
//     frame_out               high while word bits are driven (tx -> link)
//   Modports: master = word source / link observer, slave = transmitter.
// -----------------------------------------------------------------------------
interface src_sync_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             clk_out;
  logic             data_out;
  logic             frame_out;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  clk_out,
    input  data_out,
    input  frame_out
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output clk_out,
    output data_out,
    output frame_out
  );
endinterface

// File: rtl/src_sync_tx.sv
// -----------------------------------------------------------------------------
// src_sync_tx
//   Source-synchronous serial transmitter. Accepts a parallel word over a
//   valid/ready handshake and shifts it out MSB first on data_out together
//   with a forwarded clock clk_out. The rising edge of clk_out sits in the
//   middle of each bit, giving DIV clk cycles of setup and DIV cycles of hold
//   to a posedge capture flop at the far end. Each bit lasts 2*DIV clk cycles,
//   and a frame is followed by a 2*DIV-cycle gap before the next word.
//
//   Every output is driven straight from a flop. clk_out is a register
//   divided from clk and must be declared as a generated clock.
//
//   Optional feature (macro SRC_SYNC_TX_PARITY_EN): appends an even-parity
//   bit (XOR of the word) after the LSB, with its own clk_out pulse.
//
//   Parameters:
//     WIDTH  bits per word (>= 2)
//     DIV    clk cycles per clk_out half-period (>= 1)
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        src_sync_tx_if.slave: data_in/data_valid/data_ready,
//                clk_out/data_out/frame_out
//     dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 GAP)
// -----------------------------------------------------------------------------
module src_sync_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  src_sync_tx_if.slave       bus,
  output logic [1:0]         dbg_state
);

`ifdef SRC_SYNC_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int DIV2 = 2 * DIV;
  localparam int DCW  = (DIV2 > 1) ? $clog2(DIV2) : 1;
  localparam int BCW  = $clog2(NBITS);

  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV2 - 1);
  localparam logic [DCW-1:0] DIV_HIGH = DCW'(DIV);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [DCW-1:0]   div_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] load_word;
  logic [DCW-1:0]   div_nxt;

  // Word as it will go onto the wire, MSB first.
`ifdef SRC_SYNC_TX_PARITY_EN
  assign load_word = {bus.data_in, ^bus.data_in};
`else
  assign load_word = bus.data_in;
`endif

  assign div_nxt   = div_cnt + 1'b1;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      bus.data_ready <= 1'b1;
      bus.clk_out    <= 1'b0;
      bus.data_out   <= 1'b0;
      bus.frame_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.clk_out   <= 1'b0;
          bus.frame_out <= 1'b0;
          if (bus.data_valid) begin
            shreg          <= load_word;
            bus.data_out   <= load_word[NBITS-1];
            div_cnt        <= '0;
            bit_cnt        <= '0;
            bus.data_ready <= 1'b0;
            bus.frame_out  <= 1'b1;
            state          <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt     <= '0;
            bus.clk_out <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              bus.frame_out <= 1'b0;
              bus.data_out  <= 1'b0;
              state         <= GAP;
            end else begin
              shreg        <= shreg << 1;
              bus.data_out <= shreg[NBITS-2];
              bit_cnt      <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt     <= div_nxt;
            // Decided from the next count so the flop is high exactly while
            // div_cnt sits in the upper half of the bit period.
            bus.clk_out <= (div_nxt >= DIV_HIGH);
          end
        end

        GAP: begin
          bus.clk_out <= 1'b0;
          if (div_cnt == DIV_LAST) begin
            div_cnt        <= '0;
            bus.data_ready <= 1'b1;
            state          <= IDLE;
          end else begin
            div_cnt <= div_nxt;
          end
        end

        default: begin
          state          <= IDLE;
          div_cnt        <= '0;
          bit_cnt        <= '0;
          bus.data_ready <= 1'b1;
          bus.clk_out    <= 1'b0;
          bus.frame_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule
